// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 master frame controller: one command word per cs_n frame, returns the MISO word.
// SCLK is derived from clk with a DIV_HALF-cycle half-period divider that only runs while busy.
module spi_frame_ctrl #(
  parameter int DIV_HALF   = 1250,
  parameter int FRAME_BITS = 16,
  parameter int GAP_HALVES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  rx_valid,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int DW = $clog2(DIV_HALF);
  localparam int BW = $clog2(FRAME_BITS + GAP_HALVES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

  state_t                r_state, w_next;
  logic [DW-1:0]         r_div;
  logic [BW-1:0]         r_bit_cnt;
  logic [FRAME_BITS-1:0] r_tx_sr, r_rx_sr, r_rx_data;
  logic                  r_sclk, r_cs_n, r_rx_valid;
  logic                  w_tick, w_accept, w_last_bit, w_gap_done;

  assign w_tick      = (r_state != S_IDLE) && (r_div == DW'(DIV_HALF - 1));
  assign w_accept    = start_valid && (r_state == S_IDLE);
  assign w_last_bit  = (r_bit_cnt == BW'(FRAME_BITS));
  assign w_gap_done  = (r_bit_cnt == BW'(GAP_HALVES - 1));

  assign start_ready = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign sclk        = r_sclk;
  assign cs_n        = r_cs_n;
  assign mosi        = r_tx_sr[FRAME_BITS-1];
  assign rx_valid    = r_rx_valid;
  assign rx_data     = r_rx_data;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // XFER keeps one low half after the last fall so rx_valid lands 2*FRAME_BITS+2 halves after acceptance
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SETUP;
      S_SETUP: if (w_tick) w_next = S_XFER;
      S_XFER:  if (w_tick && !r_sclk && w_last_bit) w_next = S_HOLD;
      S_HOLD:  if (w_tick) w_next = S_GAP;
      S_GAP:   if (w_tick && w_gap_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= '0;
      r_bit_cnt  <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (r_state == S_IDLE) r_div <= '0;
      else                   r_div <= w_tick ? '0 : r_div + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_sclk <= 1'b0;
          if (w_accept) begin
            r_tx_sr   <= tx_data;
            r_cs_n    <= 1'b0;
            r_bit_cnt <= '0;
          end
        end
        S_SETUP: begin
          if (w_tick) begin
            r_sclk    <= 1'b1;
            r_rx_sr   <= {r_rx_sr[FRAME_BITS-2:0], miso};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_XFER: begin
          if (w_tick) begin
            if (r_sclk) begin
              r_sclk <= 1'b0;
              if (!w_last_bit) r_tx_sr <= {r_tx_sr[FRAME_BITS-2:0], 1'b0};
            end else if (!w_last_bit) begin
              r_sclk    <= 1'b1;
              r_rx_sr   <= {r_rx_sr[FRAME_BITS-2:0], miso};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            r_cs_n     <= 1'b1;
            r_rx_data  <= r_rx_sr;
            r_rx_valid <= 1'b1;
            r_bit_cnt  <= '0;
          end
        end
        S_GAP: begin
          if (w_tick) r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Scoreboard bench for spi_frame_ctrl: small-parameter instance for function, default instance for rate.
module tb_spi_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready, rx_valid, busy, sclk, mosi, miso, cs_n;
  logic [7:0] tx_data = '0;
  logic [7:0] rx_data;
  int         mode = 0;  // 0 loopback, 1 miso=1, 2 miso=0

  logic        d_start_valid = 1'b0;
  logic        d_start_ready, d_rx_valid, d_busy, d_sclk, d_mosi, d_cs_n;
  logic [15:0] d_tx_data = '0;
  logic [15:0] d_rx_data;

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;

  typedef struct {
    logic [7:0] data;
    int         acc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign miso = (mode == 0) ? mosi : (mode == 1) ? 1'b1 : 1'b0;

  spi_frame_ctrl #(.DIV_HALF(4), .FRAME_BITS(8), .GAP_HALVES(2)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_frame_ctrl dut_d (
    .clk(clk), .rst(rst), .start_valid(d_start_valid), .start_ready(d_start_ready),
    .tx_data(d_tx_data), .rx_valid(d_rx_valid), .rx_data(d_rx_data), .busy(d_busy),
    .sclk(d_sclk), .mosi(d_mosi), .miso(d_mosi), .cs_n(d_cs_n)
  );

  // push on acceptance, pop and compare on rx_valid
  always @(negedge clk) begin
    exp_t e;
    if (!rst && start_valid && start_ready) begin
      e.data = (mode == 0) ? tx_data : (mode == 1) ? 8'hFF : 8'h00;
      e.acc  = cyc + 1;
      sb.push_back(e);
    end
    if (rx_valid) begin
      vec++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL rx_unexpected: rx_valid with data %h, expected none", rx_data);
      end else begin
        e = sb.pop_front();
        if (rx_data !== e.data) begin
          errs++;
          $display("FAIL rx_data: got %h expected %h", rx_data, e.data);
        end
        vec++;
        if (cyc - e.acc != 72) begin
          errs++;
          $display("FAIL rx_latency: got %0d expected 72", cyc - e.acc);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    @(posedge clk); #1;
    tx_data = d; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic check_sb_empty(input string name);
    vec++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL %s sb_empty: %0d entries left, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vec++;
    if ({cs_n, sclk, mosi, rx_valid, busy, start_ready} !== 6'b100001) begin
      errs++;
      $display("FAIL reset_ctl: got cs,sclk,mosi,rxv,busy,rdy=%b expected 100001",
               {cs_n, sclk, mosi, rx_valid, busy, start_ready});
    end
    vec++;
    if (rx_data !== 8'h00) begin
      errs++;
      $display("FAIL reset_rx_data: got %h expected 00", rx_data);
    end
  endtask

  task automatic test_loopback;
    int rises = 0, hi_len = 0, lo_len = 0, bad_phase = 0, vcnt = 0, cs_bad = 0;
    logic prev_sclk = 1'b0, prev_cs = 1'b0;
    logic [7:0] mbits = '0;
    mode = 0;
    send(8'hA5);
    repeat (90) begin
      @(negedge clk);
      if (sclk && !prev_sclk) begin
        if (rises < 8) mbits[7-rises] = mosi;
        if (rises > 0 && lo_len != 4) bad_phase++;
        rises++;
        hi_len = 0;
      end
      if (!sclk && prev_sclk) begin
        if (hi_len != 4) bad_phase++;
        lo_len = 0;
      end
      if (sclk) hi_len++; else lo_len++;
      if (rx_valid) begin
        vcnt++;
        if (!(cs_n && !prev_cs)) cs_bad++;
      end
      prev_sclk = sclk;
      prev_cs   = cs_n;
    end
    vec++;
    if (rises != 8) begin errs++; $display("FAIL lb_pulses: got %0d expected 8", rises); end
    vec++;
    if (bad_phase != 0) begin errs++; $display("FAIL lb_phase: %0d phases not 4 cycles, expected 0", bad_phase); end
    vec++;
    if (mbits !== 8'hA5) begin errs++; $display("FAIL lb_mosi: got %h expected a5", mbits); end
    vec++;
    if (vcnt != 1 || cs_bad != 0) begin
      errs++;
      $display("FAIL lb_csn_rxv: got rxv=%0d csbad=%0d expected 1 0", vcnt, cs_bad);
    end
    check_sb_empty("loopback");
  endtask

  task automatic test_const_miso;
    int mosi_bad = 0;
    mode = 1;
    send(8'h00);
    repeat (85) begin @(negedge clk); if (mosi !== 1'b0) mosi_bad++; end
    mode = 2;
    send(8'h00);
    repeat (85) begin @(negedge clk); if (mosi !== 1'b0) mosi_bad++; end
    vec++;
    if (mosi_bad != 0) begin errs++; $display("FAIL const_mosi: %0d samples high, expected 0", mosi_bad); end
    check_sb_empty("const_miso");
    mode = 0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [3] = '{8'h3C, 8'hC3, 8'h81};
    int acc_n = 0, g = 0;
    int rlow = 0, ready_runs = 0, ready_bad = 0, chigh = 0, cs_runs = 0, cs_bad = 0;
    logic seen = 1'b0;
    mode = 0;
    @(posedge clk); #1;
    tx_data = vals[0]; start_valid = 1'b1;
    fork
      begin
        while (acc_n < 3 && g < 2000) begin
          @(negedge clk); g++;
          if (start_ready) begin
            acc_n++;
            @(posedge clk); #1;
            if (acc_n < 3) tx_data = vals[acc_n];
            else start_valid = 1'b0;
          end
        end
        start_valid = 1'b0;
      end
      begin
        repeat (253) begin
          @(negedge clk);
          if (!start_ready) rlow++;
          else begin
            if (rlow > 0) begin ready_runs++; if (rlow != 80) ready_bad++; end
            rlow = 0;
          end
          if (rx_valid) seen = 1'b1;
          if (cs_n) chigh++;
          else begin
            if (seen && chigh > 0) begin cs_runs++; if (chigh != 9) cs_bad++; end
            chigh = 0;
          end
        end
      end
    join
    vec++;
    if (acc_n != 3) begin errs++; $display("FAIL b2b_accepts: got %0d expected 3", acc_n); end
    vec++;
    if (ready_runs != 3 || ready_bad != 0) begin
      errs++;
      $display("FAIL b2b_ready_low: runs=%0d bad=%0d expected 3 runs of 80", ready_runs, ready_bad);
    end
    vec++;
    if (cs_runs != 2 || cs_bad != 0) begin
      errs++;
      $display("FAIL b2b_csn_gap: runs=%0d bad=%0d expected 2 runs of 9", cs_runs, cs_bad);
    end
    check_sb_empty("back_to_back");
  endtask

  task automatic test_ignore_busy;
    int vcnt = 0;
    mode = 0;
    send(8'h96);
    repeat (20) @(posedge clk);
    #1 tx_data = 8'h3C; start_valid = 1'b1;
    @(posedge clk); #1 start_valid = 1'b0;
    repeat (150) begin @(negedge clk); if (rx_valid) vcnt++; end
    vec++;
    if (vcnt != 1) begin errs++; $display("FAIL ignore_rxv: got %0d expected 1", vcnt); end
    vec++;
    if (busy !== 1'b0 || cs_n !== 1'b1) begin
      errs++;
      $display("FAIL ignore_idle: got busy=%b cs_n=%b expected 0 1", busy, cs_n);
    end
    check_sb_empty("ignore_busy");
  endtask

  task automatic test_reset_mid;
    int vcnt = 0;
    mode = 0;
    send(8'h77);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    vec++;
    if ({cs_n, sclk, busy, start_ready} !== 4'b1001) begin
      errs++;
      $display("FAIL rstmid_ctl: got cs,sclk,busy,rdy=%b expected 1001", {cs_n, sclk, busy, start_ready});
    end
    repeat (100) begin @(negedge clk); if (rx_valid) vcnt++; end
    vec++;
    if (vcnt != 0) begin errs++; $display("FAIL rstmid_rxv: got %0d expected 0", vcnt); end
    send(8'h5A);
    repeat (90) @(negedge clk);
    check_sb_empty("reset_mid");
  endtask

  task automatic test_default;
    logic [15:0] sbd[$];
    logic [15:0] e;
    int t = 0, r1 = -1, r2 = -1, rxt = -1;
    logic prev = 1'b0;
    @(posedge clk); #1;
    d_tx_data = 16'h8001; d_start_valid = 1'b1;
    sbd.push_back(16'h8001);
    @(posedge clk); #1 d_start_valid = 1'b0;
    while (rxt < 0 && t < 43000) begin
      @(negedge clk);
      if (d_sclk && !prev) begin
        if (r1 < 0) r1 = t;
        else if (r2 < 0) r2 = t;
      end
      prev = d_sclk;
      if (d_rx_valid) begin
        rxt = t;
        vec++;
        if (sbd.size() == 0) begin
          errs++;
          $display("FAIL def_rx_unexpected: data %h", d_rx_data);
        end else begin
          e = sbd.pop_front();
          if (d_rx_data !== e) begin errs++; $display("FAIL def_rx_data: got %h expected %h", d_rx_data, e); end
        end
      end
      t++;
    end
    vec++;
    if (r2 - r1 != 2500) begin errs++; $display("FAIL def_sclk_period: got %0d expected 2500", r2 - r1); end
    vec++;
    if (rxt != 42500) begin errs++; $display("FAIL def_rx_latency: got %0d expected 42500", rxt); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_const_miso();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_default();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
